// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the MIPS ALU.
//   - alu_op_t        : 4-bit ALU-control code type
//   - ALU_* constants : the op encodings understood by mips_alu
//   - uses_subtract() : 1 for ops that run the adder as a + ~b + 1
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_SLT = 4'b0111;
    localparam alu_op_t ALU_NOR = 4'b1100;

    // SLT is decided from the sign of a - b, so it shares the subtract path.
    function automatic logic uses_subtract(input alu_op_t op);
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_adder.sv
// alu_adder: combinational WIDTH-bit adder shared by ADD, SUB and SLT.
// Ports:
//   a, b       : operands
//   invert_b   : 1 -> add ~b instead of b (subtraction)
//   carry_in   : carry into bit 0 (1 together with invert_b gives a - b)
//   sum        : WIDTH-bit sum
//   carry_out  : carry out of bit WIDTH-1
//   overflow   : signed overflow of a + b_eff + carry_in
module alu_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    // Conditional inversion of b, one XOR per bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_eff[gi] = b[gi] ^ invert_b;
        end
    endgenerate

    assign full_sum  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    assign sum       = full_sum[WIDTH-1:0];
    assign carry_out = full_sum[WIDTH];

    // Overflow: both addends share a sign and the sum's sign differs from it.
    // With invert_b this becomes "a and b differ in sign, result sign != a".
    assign overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/mips_alu.sv
// mips_alu: registered WIDTH-bit ALU (AND, OR, ADD, SUB, SLT, NOR).
// Outputs are captured on the rising edge of clk; reset is asynchronous.
// Ports:
//   clk      : system clock, rising-edge active
//   reset    : asynchronous active-high reset (result=0, flags=0, zero=1)
//   a, b     : operands
//   op       : ALU control code (see alu_pkg)
//   zero     : registered, 1 when registered result == 0
//   result   : registered operation result
//   overflow : registered signed-overflow flag (ADD/SUB only)
//   carry    : registered carry-out flag (ADD/SUB only)
import alu_pkg::*;

module mips_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             zero,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry
);

    logic             sub_mode;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             add_ovf;

    logic [WIDTH-1:0] result_next;
    logic             overflow_next;
    logic             carry_next;
    logic             zero_next;
    logic             slt_bit;

    assign sub_mode = uses_subtract(alu_op_t'(op));

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a         (a),
        .b         (b),
        .invert_b  (sub_mode),
        .carry_in  (sub_mode),
        .sum       (add_sum),
        .carry_out (add_carry),
        .overflow  (add_ovf)
    );

    // Signed less-than that survives overflow of a - b.
    assign slt_bit = add_sum[WIDTH-1] ^ add_ovf;

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        carry_next    = 1'b0;
        case (op)
            ALU_AND: result_next = a & b;
            ALU_OR:  result_next = a | b;
            ALU_ADD: begin
                result_next   = add_sum;
                overflow_next = add_ovf;
                carry_next    = add_carry;
            end
            ALU_SUB: begin
                result_next   = add_sum;
                overflow_next = add_ovf;
                carry_next    = add_carry;
            end
            ALU_SLT: result_next = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_NOR: result_next = ~(a | b);
            default: ; // undefined (or unknown) codes produce all-zero outputs
        endcase
        zero_next = (result_next == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            overflow <= 1'b0;
            carry    <= 1'b0;
            zero     <= 1'b1;
        end else begin
            result   <= result_next;
            overflow <= overflow_next;
            carry    <= carry_next;
            zero     <= zero_next;
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: self-checking bench for mips_alu (WIDTH=32).
// Directed vectors from a table plus random vectors checked against an
// arithmetic reference model; expectations travel through a scoreboard
// queue and are compared one cycle after they are driven.
module tb_mips_alu;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         zero;
    logic [W-1:0] result;
    logic         overflow;
    logic         carry;

    mips_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .op       (op),
        .zero     (zero),
        .result   (result),
        .overflow (overflow),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         ovf;
        logic         cy;
    } vec_t;

    int n_compared   = 0;
    int n_mismatched = 0;

    vec_t sb[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input vec_t e);
        check({e.name, ".result"},   result,                    e.res);
        check({e.name, ".zero"},     {{(W-1){1'b0}}, zero},     {{(W-1){1'b0}}, e.z});
        check({e.name, ".overflow"}, {{(W-1){1'b0}}, overflow}, {{(W-1){1'b0}}, e.ovf});
        check({e.name, ".carry"},    {{(W-1){1'b0}}, carry},    {{(W-1){1'b0}}, e.cy});
        $display("txn %-14s op=%b a=%h b=%h -> result=%h z=%b v=%b c=%b",
                 e.name, e.op, e.a, e.b, result, zero, overflow, carry);
    endtask

    // Called at a falling edge: retire the transaction captured at the
    // previous rising edge, then drive the next one (if any).
    task automatic step(input logic drive, input vec_t v);
        vec_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_outputs(e);
        end
        if (drive) begin
            op = v.op;
            a  = v.a;
            b  = v.b;
            sb.push_back(v);
        end
    endtask

    // Reference model using wide signed/unsigned arithmetic.
    function automatic vec_t model(input string name, input logic [3:0] o,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t   v;
        longint sx;
        longint sy;
        longint s;
        v.name = name; v.op = o; v.a = x; v.b = y;
        v.res = '0; v.ovf = 1'b0; v.cy = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'b0000: v.res = x & y;
            4'b0001: v.res = x | y;
            4'b0010: begin
                s     = sx + sy;
                v.res = x + y;
                v.cy  = (longint'(x) + longint'(y)) > 64'sd4294967295;
                v.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s     = sx - sy;
                v.res = x - y;
                v.cy  = (x >= y);
                v.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: v.res = (sx < sy) ? 32'd1 : 32'd0;
            4'b1100: v.res = ~(x | y);
            default: ;
        endcase
        v.z = (v.res == 32'd0);
        return v;
    endfunction

    vec_t       tbl[15];
    vec_t       v;
    vec_t       none;
    logic [3:0] op_list[8];

    initial begin
        //                name          op       a             b             result        z     v     c
        tbl[0]  = '{"and_3_2",    4'b0000, 32'd3,        32'd2,        32'd2,        1'b0, 1'b0, 1'b0};
        tbl[1]  = '{"or_3_2",     4'b0001, 32'd3,        32'd2,        32'd3,        1'b0, 1'b0, 1'b0};
        tbl[2]  = '{"add_3_2",    4'b0010, 32'd3,        32'd2,        32'd5,        1'b0, 1'b0, 1'b0};
        tbl[3]  = '{"sub_3_2",    4'b0110, 32'd3,        32'd2,        32'd1,        1'b0, 1'b0, 1'b1};
        tbl[4]  = '{"slt_3_2",    4'b0111, 32'd3,        32'd2,        32'd0,        1'b1, 1'b0, 1'b0};
        tbl[5]  = '{"nor_3_2",    4'b1100, 32'd3,        32'd2,        32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{"add_ovf",    4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{"add_wrap",   4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b1};
        tbl[8]  = '{"sub_eq",     4'b0110, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1'b1};
        tbl[9]  = '{"sub_ovf",    4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{"sub_borrow", 4'b0110, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{"slt_neg",    4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
        tbl[12] = '{"slt_ovf",    4'b0111, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
        tbl[13] = '{"slt_max",    4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b0, 1'b0};
        tbl[14] = '{"undef_0101", 4'b0101, 32'd3,        32'd2,        32'd0,        1'b1, 1'b0, 1'b0};

        op_list[0] = 4'b0000; op_list[1] = 4'b0001; op_list[2] = 4'b0010; op_list[3] = 4'b0110;
        op_list[4] = 4'b0111; op_list[5] = 4'b1100; op_list[6] = 4'b0101; op_list[7] = 4'b1111;

        none = '{"none", 4'b0000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0};

        // Reset asserted from time zero, inputs set to something non-trivial.
        reset = 1'b1;
        op    = 4'b0010;
        a     = 32'd3;
        b     = 32'd2;
        #2;
        check_outputs('{"reset_t0", 4'b0010, 32'd3, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        check_outputs('{"reset_held", 4'b0010, 32'd3, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 15; i++) step(1'b1, tbl[i]);

        // Random vectors against the reference model, biased toward edge values.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            x = $urandom();
            y = $urandom();
            if (i % 5 == 0) x = {x[0], {(W-1){x[1]}}};
            if (i % 7 == 0) y = x;
            v = model($sformatf("rand_%0d", i), op_list[$urandom_range(0, 7)], x, y);
            step(1'b1, v);
        end
        step(1'b0, none);

        // Asynchronous reset between edges while result holds 5.
        op = 4'b0010;
        a  = 32'd3;
        b  = 32'd2;
        @(posedge clk);
        #2;
        check_outputs('{"pre_reset", 4'b0010, 32'd3, 32'd2, 32'd5, 1'b0, 1'b0, 1'b0});
        #2;
        reset = 1'b1;
        #1;
        check_outputs('{"async_reset", 4'b0010, 32'd3, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        check_outputs('{"reset_hold", 4'b0010, 32'd3, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0});

        // Release: first capture is the op present at the next rising edge.
        @(negedge clk);
        reset = 1'b0;
        op    = 4'b0010;
        a     = 32'd7;
        b     = 32'd1;
        @(posedge clk);
        #1;
        check_outputs('{"post_release", 4'b0010, 32'd7, 32'd1, 32'd8, 1'b0, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Registered 32-bit ALU for the MIPS single-cycle/pipelined datapath.
- Performs AND, OR, ADD, SUB, SLT and NOR on two operands, selected by a 4-bit ALU-control code.
- Result and status flags (zero, overflow, carry) are captured on the rising clock edge and feed the writeback/branch logic.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A (rs value).
- b  input  WIDTH  operand B (rt value or immediate).
- op  input  4  ALU control code.
- zero  output  1  registered; 1 when registered result == 0.
- result  output  WIDTH  registered operation result.
- overflow  output  1  registered signed-overflow flag.
- carry  output  1  registered carry-out flag.

Behaviour:
- Reset: when reset=1, result=0, overflow=0, carry=0 and zero=1 immediately, independent of clk. This holds while reset is asserted.
- Reset mid-operation discards the pending computation. The first capture after release is at the first rising edge with reset=0.
- Latency: 1 cycle. Inputs are sampled at a rising edge; outputs update at that edge and hold until the next edge.
- No handshake: a new operation is accepted every cycle.
- op encoding:
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, mod 2^WIDTH.
  - 0110 SUB: a - b, computed as a + ~b + 1.
  - 0111 SLT: result = 1 if signed(a) < signed(b), else 0, zero-extended. Must be correct even when a - b overflows: use sign(a - b) XOR overflow(a - b).
  - 1100 NOR: ~(a | b).
  - Any other code: result = 0, overflow = 0, carry = 0.
- overflow:
  - ADD: 1 when a and b have the same sign and the sum's sign differs.
  - SUB: 1 when a and b have different signs and the difference's sign differs from a.
  - 0 for all other ops, including SLT.
- carry:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: carry-out of a + ~b + 1, i.e. 1 when unsigned a >= unsigned b.
  - 0 for all other ops.
- zero: derived from the result value being registered, in the same edge. Valid for every op, including undefined codes (zero=1 there).
- X/unknown op: treated as an undefined code. No latches; every output is assigned in every path.

Decomposition:
- Shared package alu_pkg holds:
  - op code constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100;
  - the alu_op_t typedef.
- One natural combinational sub-module, alu_adder. It is a WIDTH-bit adder with carry-in and invert-b control, and returns sum, carry-out and signed overflow. It is shared by ADD, SUB and SLT.
- The top level holds the operation mux and the output register.

Test Plan:
- a=3, b=2, apply each op for one cycle; after the next edge require:
  - AND → result=2;
  - OR → 3;
  - ADD → 5, carry=0, overflow=0;
  - SUB → 1, carry=1;
  - SLT → 0, zero=1;
  - NOR → 0xFFFFFFFC.
- ADD a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1, carry=0. ADD a=0xFFFFFFFF, b=1 → result=0, zero=1, carry=1, overflow=0.
- SUB:
  - a=5, b=5 → result=0, zero=1, carry=1;
  - a=0x80000000, b=1 → result=0x7FFFFFFF, overflow=1;
  - a=1, b=2 → result=0xFFFFFFFF, carry=0.
- SLT:
  - a=0xFFFFFFFF (-1), b=1 → result=1;
  - a=0x80000000, b=1 → result=1 (overflow case);
  - a=0x7FFFFFFF, b=0x80000000 → result=0;
  - overflow flag 0 in all three.
- Undefined op=4'b0101 with a=3, b=2 → result=0, zero=1, overflow=0, carry=0.
- Assert reset between edges while result=5 → outputs go to result=0, zero=1 with no clock edge. Hold reset across edges: outputs stay reset. Release: the next edge captures the current op.
